mux_operand_stage: RTL and testbench
====================================

// Module: mux_operand_stage
// PURPOSE
//   2-entry registered operand buffer sitting directly upstream of the 2-input
//   word mux. Accepts {A,B,SEL} operand triples from the producer over a
//   valid/ready handshake and presents them, in order, on the mux inputs.
//   Decouples producer stalls from mux/ALU consumption; no combinational path
//   from OUT_READY to IN_READY.
// PARAMETERS
//   k   4   operand width in bits; matches the mux width parameter
//   CW  8   width of the transfer counter (only with MOS_STATS_EN)
// PORTS
//   CLK        in   1    clock; all state changes on rising edge
//   RST        in   1    synchronous reset, active-high
//   FLUSH      in   1    synchronous clear of buffered entries
//   IN_VALID   in   1    producer has a triple on IN_A/IN_B/IN_SEL
//   IN_READY   out  1    stage can accept a triple this cycle
//   IN_A       in   k    operand A
//   IN_B       in   k    operand B
//   IN_SEL     in   1    mux select for this triple
//   OUT_VALID  out  1    head entry valid on OUT_A/OUT_B/OUT_SEL
//   OUT_READY  in   1    downstream consumes the head entry this cycle
//   OUT_A      out  k    head operand A -> mux A
//   OUT_B      out  k    head operand B -> mux B
//   OUT_SEL    out  1    head select -> mux SEL
//   COUNT      out  2    occupancy: 0, 1 or 2
//   XFER_CNT   out  CW   completed output transfers (only with MOS_STATS_EN)
// BEHAVIOUR
//   - push = IN_VALID & IN_READY; pop = OUT_VALID & OUT_READY.
//   - FSM states EMPTY(COUNT=0), ONE(1), FULL(2); COUNT and flags registered.
//   - IN_READY = (state != FULL) & ~RST. OUT_VALID = (state != EMPTY).
//   - EMPTY: push -> ONE; pop impossible.
//   - ONE: push & ~pop -> FULL (new entry behind head); pop & ~push -> EMPTY;
//     push & pop -> ONE, new triple becomes head next cycle.
//   - FULL: pop -> ONE, second entry becomes head; no push (IN_READY=0).
//   - Latency: triple pushed in cycle N appears on OUT_* in cycle N+1 when the
//     buffer was empty; strict FIFO order otherwise.
//   - OUT_A/OUT_B/OUT_SEL hold stable while OUT_VALID=1 and no pop occurs.
//   - When EMPTY, OUT_A/OUT_B/OUT_SEL hold last value (don't care to consumer).
//   - RST (highest priority): state EMPTY, COUNT=0, OUT_VALID=0, OUT_A=0,
//     OUT_B=0, OUT_SEL=0, IN_READY=0 while RST=1; IN_READY=1 cycle after release.
//   - FLUSH (below RST, above push/pop): next state EMPTY, COUNT=0; a push or
//     pop coincident with FLUSH is discarded/not counted; data regs unchanged.
//   - Reset or flush mid-operation drops all buffered triples; no partial state.
// CONFIGURATION
//   MOS_STATS_EN defined: XFER_CNT port present; increments by 1 on every pop,
//     wraps 2^CW-1 -> 0, cleared to 0 by RST only (FLUSH does not clear).
//   MOS_STATS_EN undefined: XFER_CNT port and counter logic absent; all other
//     behaviour identical.
// TESTING
//   1. RST=1 2 cycles, release -> IN_READY=0 during RST, then 1; OUT_VALID=0,
//      OUT_A=OUT_B=0, OUT_SEL=0, COUNT=0.
//   2. Push {A=3,B=C,SEL=1} with OUT_READY=0 -> next cycle OUT_VALID=1,
//      OUT_A=3, OUT_B=C, OUT_SEL=1, COUNT=1; held stable 5 cycles.
//   3. Push {1,2,0},{4,5,1} OUT_READY=0 -> COUNT=2, IN_READY=0; raise OUT_READY
//      -> pops in order {1,2,0} then {4,5,1}, COUNT 2->1->0.
//   4. COUNT=1, push {7,8,1} and pop same cycle -> COUNT stays 1, head={7,8,1}.
//   5. COUNT=2, assert FLUSH with IN_VALID=1 and OUT_READY=1 -> next cycle
//      COUNT=0, OUT_VALID=0, IN_READY=1; XFER_CNT unchanged.
//   6. MOS_STATS_EN, CW=2: 5 pops -> XFER_CNT 1,2,3,0,1; RST -> 0.

Source files
------------

// File: rtl/mux_operand_stage.sv
// -----------------------------------------------------------------------------
// mux_operand_stage
//   Two-entry registered operand buffer placed directly in front of the 2-input
//   word mux. The producer hands over {A,B,SEL} triples through a valid/ready
//   handshake. The triples are presented on OUT_* in strict FIFO order.
//   IN_READY depends only on registered state and RST. It never depends on
//   OUT_READY, so producer and consumer stalls stay decoupled.
//
//   Optional feature, controlled by the `MOS_STATS_EN macro:
//     defined   -> the CW parameter and the XFER_CNT port exist, and
//                  XFER_CNT counts completed output transfers.
//     undefined -> the counter and its port are absent. The default build
//                  leaves the macro undefined.
// -----------------------------------------------------------------------------
module mux_operand_stage #(
   parameter int k  = 4
`ifdef MOS_STATS_EN
  ,parameter int CW = 8
`endif
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          FLUSH,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic [k-1:0]  IN_A,
   input  logic [k-1:0]  IN_B,
   input  logic          IN_SEL,
   output logic          OUT_VALID,
   input  logic          OUT_READY,
   output logic [k-1:0]  OUT_A,
   output logic [k-1:0]  OUT_B,
   output logic          OUT_SEL,
   output logic [1:0]    COUNT
`ifdef MOS_STATS_EN
  ,output logic [CW-1:0] XFER_CNT
`endif
);

   // The state encoding equals the occupancy, so COUNT is the state itself.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_next_state;

   logic [k-1:0]   r_head_a;
   logic [k-1:0]   r_head_b;
   logic           r_head_sel;
   logic [k-1:0]   r_tail_a;
   logic [k-1:0]   r_tail_b;
   logic           r_tail_sel;

   logic           w_push;
   logic           w_pop;
   logic           w_push_eff;
   logic           w_pop_eff;

   assign w_push     = IN_VALID & IN_READY;
   assign w_pop      = OUT_VALID & OUT_READY;
   // FLUSH discards any handshake that happens in the same cycle.
   assign w_push_eff = w_push & ~FLUSH;
   assign w_pop_eff  = w_pop  & ~FLUSH;

   // State register: RST has the highest priority.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking (<=) assignments, so every
      // register samples the values from before the edge.
      if (RST) r_state <= ST_EMPTY;
      else     r_state <= w_next_state;
   end

   // Next-state logic: FLUSH wins over push/pop; otherwise track occupancy.
   always_comb begin
      // NOTE: the default assignment comes first, so no path leaves
      // w_next_state unassigned and no latch is inferred.
      w_next_state = r_state;
      if (FLUSH) begin
         w_next_state = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_push_eff) w_next_state = ST_ONE;
            ST_ONE: begin
               if (w_push_eff && !w_pop_eff)      w_next_state = ST_FULL;
               else if (w_pop_eff && !w_push_eff) w_next_state = ST_EMPTY;
            end
            ST_FULL:  if (w_pop_eff) w_next_state = ST_ONE;
            default:  w_next_state = ST_EMPTY;
         endcase
      end
   end

   // Output decode: flags and occupancy depend only on registered state and RST.
   always_comb begin
      IN_READY  = (r_state != ST_FULL) & ~RST;
      OUT_VALID = (r_state != ST_EMPTY);
      COUNT     = r_state;
   end

   // Data path: the head feeds the mux, and the tail holds the second entry.
   always_ff @(posedge CLK) begin
      // NOTE: the data registers are reset because OUT_A, OUT_B and OUT_SEL
      // must read zero during reset. FLUSH only clears the state, so the data
      // registers keep their values.
      if (RST) begin
         r_head_a   <= '0;
         r_head_b   <= '0;
         r_head_sel <= 1'b0;
         r_tail_a   <= '0;
         r_tail_b   <= '0;
         r_tail_sel <= 1'b0;
      end else begin
         if (w_pop_eff && r_state == ST_FULL) begin
            r_head_a   <= r_tail_a;
            r_head_b   <= r_tail_b;
            r_head_sel <= r_tail_sel;
         end else if (w_push_eff && (r_state == ST_EMPTY || w_pop_eff)) begin
            r_head_a   <= IN_A;
            r_head_b   <= IN_B;
            r_head_sel <= IN_SEL;
         end
         if (w_push_eff && !w_pop_eff && r_state == ST_ONE) begin
            r_tail_a   <= IN_A;
            r_tail_b   <= IN_B;
            r_tail_sel <= IN_SEL;
         end
      end
   end

   assign OUT_A   = r_head_a;
   assign OUT_B   = r_head_b;
   assign OUT_SEL = r_head_sel;

`ifdef MOS_STATS_EN
   logic [CW-1:0] r_xfer_cnt;

   // Transfer counter: counts pops and wraps naturally. Only RST clears it;
   // FLUSH does not.
   always_ff @(posedge CLK) begin
      if (RST)            r_xfer_cnt <= '0;
      else if (w_pop_eff) r_xfer_cnt <= r_xfer_cnt + 1'b1;
   end

   assign XFER_CNT = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_mux_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_mux_operand_stage
//   Directed-vector bench for mux_operand_stage with k=4. The transfer-counter
//   checks are compiled in only when `MOS_STATS_EN is defined; that build uses
//   CW=2.
// -----------------------------------------------------------------------------
module tb_mux_operand_stage;

   localparam int K  = 4;
   localparam int CW = 2;

   logic          CLK = 1'b0;
   logic          RST;
   logic          FLUSH;
   logic          IN_VALID;
   logic          IN_READY;
   logic [K-1:0]  IN_A;
   logic [K-1:0]  IN_B;
   logic          IN_SEL;
   logic          OUT_VALID;
   logic          OUT_READY;
   logic [K-1:0]  OUT_A;
   logic [K-1:0]  OUT_B;
   logic          OUT_SEL;
   logic [1:0]    COUNT;
`ifdef MOS_STATS_EN
   logic [CW-1:0] XFER_CNT;
   logic [CW-1:0] exp_xfer;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mux_operand_stage #(
      .k(K)
`ifdef MOS_STATS_EN
     ,.CW(CW)
`endif
   ) dut (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .IN_A(IN_A), .IN_B(IN_B), .IN_SEL(IN_SEL),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .OUT_A(OUT_A), .OUT_B(OUT_B), .OUT_SEL(OUT_SEL),
      .COUNT(COUNT)
`ifdef MOS_STATS_EN
     ,.XFER_CNT(XFER_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit before sampling or driving.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_in(input logic v, input logic [K-1:0] a, input logic [K-1:0] b, input logic s);
      IN_VALID = v;
      IN_A     = a;
      IN_B     = b;
      IN_SEL   = s;
   endtask

   task automatic check_head(input string tag, input logic [K-1:0] a, input logic [K-1:0] b, input logic s);
      check({tag, "_valid"}, 32'(OUT_VALID), 32'd1);
      check({tag, "_a"},     32'(OUT_A),     32'(a));
      check({tag, "_b"},     32'(OUT_B),     32'(b));
      check({tag, "_sel"},   32'(OUT_SEL),   32'(s));
   endtask

   initial begin
      RST = 1'b1; FLUSH = 1'b0; OUT_READY = 1'b0;
      drive_in(1'b0, '0, '0, 1'b0);
`ifdef MOS_STATS_EN
      exp_xfer = '0;
`endif

      // 1. Reset for two cycles, then release.
      tick(); tick();
      check("rst_in_ready",  32'(IN_READY),  32'd0);
      check("rst_out_valid", 32'(OUT_VALID), 32'd0);
      check("rst_count",     32'(COUNT),     32'd0);
      check("rst_out_a",     32'(OUT_A),     32'd0);
      check("rst_out_b",     32'(OUT_B),     32'd0);
      check("rst_out_sel",   32'(OUT_SEL),   32'd0);
      RST = 1'b0;
      tick();
      check("post_rst_in_ready", 32'(IN_READY), 32'd1);
      check("post_rst_count",    32'(COUNT),    32'd0);

      // 2. Single push of {3,C,1} into an empty buffer: visible next cycle and held.
      drive_in(1'b1, 4'h3, 4'hC, 1'b1);
      tick();
      drive_in(1'b0, '0, '0, 1'b0);
      check_head("t2", 4'h3, 4'hC, 1'b1);
      check("t2_count", 32'(COUNT), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_head("t2_hold", 4'h3, 4'hC, 1'b1);
      end
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
`ifdef MOS_STATS_EN
      exp_xfer = exp_xfer + 1'b1;
`endif
      check("t2_drain_count", 32'(COUNT),     32'd0);
      check("t2_drain_valid", 32'(OUT_VALID), 32'd0);

      // 3. Fill both entries, then drain them in FIFO order.
      drive_in(1'b1, 4'h1, 4'h2, 1'b0);
      tick();
      drive_in(1'b1, 4'h4, 4'h5, 1'b1);
      tick();
      drive_in(1'b0, '0, '0, 1'b0);
      check("t3_full_count",    32'(COUNT),    32'd2);
      check("t3_full_in_ready", 32'(IN_READY), 32'd0);
      check_head("t3_head0", 4'h1, 4'h2, 1'b0);
      OUT_READY = 1'b1;
      tick();
      check_head("t3_head1", 4'h4, 4'h5, 1'b1);
      check("t3_count1", 32'(COUNT), 32'd1);
      tick();
      OUT_READY = 1'b0;
`ifdef MOS_STATS_EN
      exp_xfer = exp_xfer + 2'd2;
`endif
      check("t3_count0", 32'(COUNT),     32'd0);
      check("t3_valid0", 32'(OUT_VALID), 32'd0);

      // 4. With one entry held, push and pop in the same cycle.
      drive_in(1'b1, 4'h9, 4'h6, 1'b0);
      tick();
      drive_in(1'b1, 4'h7, 4'h8, 1'b1);
      OUT_READY = 1'b1;
      tick();
      drive_in(1'b0, '0, '0, 1'b0);
      OUT_READY = 1'b0;
`ifdef MOS_STATS_EN
      exp_xfer = exp_xfer + 1'b1;
`endif
      check("t4_count", 32'(COUNT), 32'd1);
      check_head("t4_head", 4'h7, 4'h8, 1'b1);

      // 5. FLUSH while full, with a coincident pop and push attempt.
      drive_in(1'b1, 4'h2, 4'h3, 1'b0);
      tick();
      check("t5_pre_count", 32'(COUNT), 32'd2);
      FLUSH = 1'b1;
      OUT_READY = 1'b1;
      drive_in(1'b1, 4'hE, 4'hE, 1'b1);
      tick();
      FLUSH = 1'b0;
      OUT_READY = 1'b0;
      drive_in(1'b0, '0, '0, 1'b0);
      check("t5_count",    32'(COUNT),     32'd0);
      check("t5_valid",    32'(OUT_VALID), 32'd0);
      check("t5_in_ready", 32'(IN_READY),  32'd1);
      check("t5_data_kept", 32'(OUT_A),    32'h7);
`ifdef MOS_STATS_EN
      check("t5_xfer", 32'(XFER_CNT), 32'(exp_xfer));
`endif

      // 5b. FLUSH from ONE discards a coincident push.
      drive_in(1'b1, 4'h5, 4'h5, 1'b1);
      tick();
      FLUSH = 1'b1;
      drive_in(1'b1, 4'hF, 4'hA, 1'b0);
      tick();
      FLUSH = 1'b0;
      drive_in(1'b0, '0, '0, 1'b0);
      check("t5b_count",  32'(COUNT), 32'd0);
      check("t5b_a_kept", 32'(OUT_A), 32'h5);

      // Reset mid-operation drops the buffered entries and zeroes the outputs.
      drive_in(1'b1, 4'hB, 4'hD, 1'b1);
      tick();
      drive_in(1'b1, 4'h6, 4'h1, 1'b0);
      tick();
      drive_in(1'b0, '0, '0, 1'b0);
      RST = 1'b1;
      tick();
      check("mid_rst_in_ready", 32'(IN_READY), 32'd0);
      check("mid_rst_count",    32'(COUNT),    32'd0);
      check("mid_rst_out_a",    32'(OUT_A),    32'd0);
      check("mid_rst_out_sel",  32'(OUT_SEL),  32'd0);
      RST = 1'b0;
      tick();

`ifdef MOS_STATS_EN
      // 6. Counter wrap with CW=2, followed by a clear on RST.
      check("t6_rst_xfer", 32'(XFER_CNT), 32'd0);
      drive_in(1'b1, 4'h0, 4'h0, 1'b0);
      tick();
      OUT_READY = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         drive_in(1'b1, 4'(i), 4'(i), 1'b0);
         tick();
         check($sformatf("t6_xfer_%0d", i), 32'(XFER_CNT), 32'(i % 4));
      end
      OUT_READY = 1'b0;
      drive_in(1'b0, '0, '0, 1'b0);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("t6_xfer_cleared", 32'(XFER_CNT), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
